// File: rtl/counter_timeout_scheduler_if.sv
// rtl/counter_timeout_scheduler_if.sv - requester and counter-control bundle for the timeout scheduler
interface counter_timeout_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_len;
  logic [NREQ*16-1:0]    req_prescale;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       expire;
  logic                  busy;
  logic                  ctr_load;
  logic                  ctr_en;
  logic                  ctr_mode;
  logic                  ctr_auto_reload;
  logic [WIDTH-1:0]      ctr_preset;
  logic [15:0]           ctr_prescale;
  logic                  ctr_done;

  // master: requesters plus the shared counter; slave: the scheduler itself
  modport master (
    output req, req_len, req_prescale, ctr_done,
    input  grant, expire, busy, ctr_load, ctr_en, ctr_mode, ctr_auto_reload,
           ctr_preset, ctr_prescale
  );

  modport slave (
    input  req, req_len, req_prescale, ctr_done,
    output grant, expire, busy, ctr_load, ctr_en, ctr_mode, ctr_auto_reload,
           ctr_preset, ctr_prescale
  );
endinterface

// File: rtl/counter_timeout_scheduler.sv
// rtl/counter_timeout_scheduler.sv - round-robin sharing of one prescaled down-counter among NREQ timeout requesters
module counter_timeout_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  counter_timeout_scheduler_if.slave bus
);
  localparam int IDXW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  logic [1:0]      state;
  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] owner;
  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] next_ptr;
  logic [IDXW:0]   cand;
  logic            found;
  logic            owner_req;

  // Scan req starting at rr_ptr, wrapping at NREQ (which need not be a power of two)
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NREQ))
        cand = cand - (IDXW+1)'(NREQ);
      if (!found && bus.req[cand[IDXW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDXW-1:0];
      end
    end
  end

  assign next_ptr  = (winner == IDXW'(NREQ-1)) ? '0 : winner + 1'b1;
  assign owner_req = bus.req[owner];

  assign bus.ctr_mode        = 1'b1;
  assign bus.ctr_auto_reload = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      owner            <= '0;
      bus.grant        <= '0;
      bus.expire       <= '0;
      bus.busy         <= 1'b0;
      bus.ctr_load     <= 1'b0;
      bus.ctr_en       <= 1'b0;
      bus.ctr_preset   <= '0;
      bus.ctr_prescale <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.expire <= '0;
          if (found) begin
            state            <= S_LOAD;
            owner            <= winner;
            rr_ptr           <= next_ptr;
            bus.grant        <= ONE_HOT0 << winner;
            bus.busy         <= 1'b1;
            bus.ctr_load     <= 1'b1;
            bus.ctr_en       <= 1'b0;
            bus.ctr_preset   <= bus.req_len[winner*WIDTH +: WIDTH];
            bus.ctr_prescale <= bus.req_prescale[winner*16 +: 16];
          end
        end
        S_LOAD: begin
          // ctr_done may still be set from the previous owner here, so only cancel is honoured
          bus.ctr_load <= 1'b0;
          if (!owner_req) begin
            state      <= S_IDLE;
            bus.grant  <= '0;
            bus.busy   <= 1'b0;
            bus.ctr_en <= 1'b0;
          end else begin
            state      <= S_RUN;
            bus.ctr_en <= 1'b1;
          end
        end
        S_RUN: begin
          // Completion takes priority over a simultaneous drop of req
          if (bus.ctr_done) begin
            state      <= S_DONE;
            bus.ctr_en <= 1'b0;
            bus.expire <= bus.grant;
          end else if (!owner_req) begin
            state      <= S_IDLE;
            bus.grant  <= '0;
            bus.busy   <= 1'b0;
            bus.ctr_en <= 1'b0;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          bus.grant  <= '0;
          bus.expire <= '0;
          bus.busy   <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          bus.grant    <= '0;
          bus.expire   <= '0;
          bus.busy     <= 1'b0;
          bus.ctr_load <= 1'b0;
          bus.ctr_en   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_counter_timeout_scheduler.sv
// tb/tb_counter_timeout_scheduler.sv - directed vector bench for counter_timeout_scheduler with a behavioural counter
module tb_counter_timeout_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_timeout_scheduler_if #(.NREQ(4), .WIDTH(8)) bus ();

  counter_timeout_scheduler #(.NREQ(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Shared counter: ticks every P+1 enabled clocks, done after the tick taken at count 0
  logic [7:0]  cnt;
  logic [15:0] pcnt;
  logic        done_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; pcnt <= '0; done_q <= 1'b0;
    end else if (bus.ctr_load) begin
      cnt <= bus.ctr_preset; pcnt <= '0; done_q <= 1'b0;
    end else if (bus.ctr_en && !done_q) begin
      if (pcnt == bus.ctr_prescale) begin
        pcnt <= '0;
        if (cnt == 8'd0) done_q <= 1'b1;
        else cnt <= cnt - 8'd1;
      end else begin
        pcnt <= pcnt + 16'd1;
      end
    end
  end
  assign bus.ctr_done = done_q;

  typedef struct {
    int idx;
    int len;
    int pre;
    int drop_after;
    int exp_edge;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int first_exp = -1;
    int bad_run = 0;
    int limit;
    logic [3:0] oh;
    oh = 4'd1 << v.idx;
    limit = (v.exp_edge < 0) ? v.drop_after + 4 : v.exp_edge + 1;
    bus.req_len[v.idx*8 +: 8]       = 8'(v.len);
    bus.req_prescale[v.idx*16 +: 16] = 16'(v.pre);
    bus.req = oh;
    for (int e = 0; e <= limit; e++) begin
      step();
      if (bus.expire != 4'd0 && first_exp < 0) first_exp = e;
      if (e == 0) begin
        check("grant_at_edge0", 32'(bus.grant), 32'(oh));
        check("load_at_edge0", 32'(bus.ctr_load), 32'd1);
        check("preset_latched", 32'(bus.ctr_preset), 32'(v.len));
        check("prescale_latched", 32'(bus.ctr_prescale), 32'(v.pre));
      end
      if (e == 1) begin
        check("en_at_edge1", 32'(bus.ctr_en), 32'd1);
        check("load_off_edge1", 32'(bus.ctr_load), 32'd0);
      end
      if (v.exp_edge < 0) begin
        if (e >= 1 && e <= v.drop_after && (bus.ctr_en !== 1'b1 || bus.ctr_prescale != 16'(v.pre)))
          bad_run++;
        if (e == v.drop_after) bus.req = '0;
        if (e == v.drop_after + 1)
          check("cancel_idle", {bus.grant, 3'b0, bus.ctr_en, 3'b0, bus.busy}, 32'd0);
      end else begin
        if (e >= 1 && e < v.exp_edge && (bus.ctr_en !== 1'b1 || bus.ctr_prescale != 16'(v.pre)))
          bad_run++;
        if (e == v.exp_edge) begin
          check("expire_owner", 32'(bus.expire), 32'(oh));
          check("en_falls_with_expire", 32'(bus.ctr_en), 32'd0);
          check("grant_held_in_done", 32'(bus.grant), 32'(oh));
          bus.req = '0;
        end
        if (e == v.exp_edge + 1)
          check("after_done_idle", {bus.grant, 3'b0, bus.busy, bus.expire}, 32'd0);
      end
    end
    check("run_phase_hold", 32'(bad_run), 32'd0);
    check("expire_edge", 32'(first_exp), 32'(v.exp_edge));
  endtask

  vec_t vecs[7];
  int order[5];

  initial begin
    bus.req = '0;
    bus.req_len = '0;
    bus.req_prescale = '0;

    vecs[0] = '{0, 3,   0, -1, 6};
    vecs[1] = '{1, 2,   4, -1, 17};
    vecs[2] = '{2, 10,  0,  5, -1};
    vecs[3] = '{3, 0,   0, -1, 3};
    vecs[4] = '{0, 1,   2, -1, 8};
    vecs[5] = '{2, 0,   3, -1, 6};
    vecs[6] = '{1, 255, 0, -1, 258};
    order   = '{0, 1, 2, 3, 0};

    // Reset state
    step();
    check("rst_grant_expire", {bus.grant, bus.expire}, 32'd0);
    check("rst_ctrl", {bus.busy, bus.ctr_load, bus.ctr_en, bus.ctr_preset, bus.ctr_prescale}, 32'd0);
    check("rst_ties", {bus.ctr_mode, bus.ctr_auto_reload}, 32'h2);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Round-robin with all requesters held, L=0 P=0
    begin
      int ng = 0;
      int g_edge = 0;
      logic [3:0] one = 4'd1;
      do_reset();
      bus.req_len = '0;
      bus.req_prescale = '0;
      bus.req = 4'hF;
      for (int e = 0; e < 60 && ng < 5; e++) begin
        step();
        if (bus.ctr_load) begin
          check("rr_grant_order", 32'(bus.grant), 32'(one << order[ng]));
          g_edge = e;
        end
        if (bus.expire != 4'd0) begin
          check("rr_expire_latency", 32'(e - g_edge), 32'd3);
          check("rr_expire_is_grant", 32'(bus.expire), 32'(bus.grant & (one << order[ng])));
          ng++;
          if (ng == 5) bus.req = '0;
        end
      end
      check("rr_five_expires", 32'(ng), 32'd5);
      step();
      step();
    end

    // Completion and owner drop in the same cycle; non-owner and owner length changes ignored
    do_reset();
    bus.req_len = '0;
    bus.req_prescale = '0;
    bus.req_len[8 +: 8] = 8'd1;
    bus.req = 4'b0010;
    step();
    check("same_cyc_grant", 32'(bus.grant), 32'h2);
    step();
    bus.req = 4'b0110;
    bus.req_len[8 +: 8] = 8'd9;
    step();
    check("nonowner_ignored", 32'(bus.grant), 32'h2);
    check("owner_len_latched", 32'(bus.ctr_preset), 32'd1);
    step();
    bus.req = 4'b0100;
    step();
    check("done_wins_expire", 32'(bus.expire), 32'h2);
    step();
    check("done_to_idle", {bus.grant, bus.expire}, 32'd0);
    step();
    check("next_owner_grant", 32'(bus.grant), 32'h4);
    check("next_owner_load", 32'(bus.ctr_load), 32'd1);
    bus.req = '0;
    step();
    check("load_cancel", {bus.grant, 2'b0, bus.busy, bus.ctr_load, bus.expire}, 32'd0);

    // Asynchronous reset in the middle of a long RUN
    begin
      int bad_exp = 0;
      do_reset();
      bus.req_len[0 +: 8] = 8'd50;
      bus.req_prescale[0 +: 16] = 16'd0;
      bus.req = 4'b0001;
      for (int e = 0; e < 10; e++) step();
      check("midrun_busy", 32'(bus.busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_a", {bus.grant, bus.expire, 5'b0, bus.busy, bus.ctr_load, bus.ctr_en, bus.ctr_preset}, 32'd0);
      check("async_rst_b", 32'(bus.ctr_prescale), 32'd0);
      bus.req = 4'b1000;
      bus.req_len[24 +: 8] = 8'd2;
      bus.req_prescale[48 +: 16] = 16'd0;
      step();
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_grant3", 32'(bus.grant), 32'h8);
      for (int e = 1; e < 5; e++) begin
        step();
        if (bus.expire != 4'd0) bad_exp++;
      end
      check("post_rst_no_early_expire", 32'(bad_exp), 32'd0);
      step();
      check("post_rst_expire3", 32'(bus.expire), 32'h8);
      bus.req = '0;
      step();
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
